// File: rtl/adc_conv_sequencer_if.sv
// Control/status bundle between the ADC conversion sequencer and its host.
// The slave side is the sequencer; the master side is the host/bench.
interface adc_conv_sequencer_if #(
  parameter int TIMEOUT_W = 12,
  parameter int CNT_W     = 16
);
  logic                 cfg_enable_in;
  logic                 cfg_continuous_in;
  logic                 conv_request_in;
  logic [3:0]           cfg_start_len_in;
  logic [7:0]           cfg_holdoff_in;
  logic [TIMEOUT_W-1:0] cfg_timeout_in;
  logic                 cfg_enable_dly_in;
  logic [4:0]           cfg_dly1_in, cfg_dly2_in, cfg_dly3_in;
  logic [5:0]           cfg_dly4_in;
  logic                 conv_finished_in;

  logic                 start_conv_out;
  logic                 ena_out;
  logic                 enable_dlycontrol_out;
  logic [4:0]           dlycontrol1_out, dlycontrol2_out, dlycontrol3_out;
  logic [5:0]           dlycontrol4_out;
  logic                 busy_out;
  logic                 done_out;
  logic                 timeout_err_out;
  logic [CNT_W-1:0]     conv_count_out;

  modport slave (
    input  cfg_enable_in, cfg_continuous_in, conv_request_in, cfg_start_len_in,
           cfg_holdoff_in, cfg_timeout_in, cfg_enable_dly_in, cfg_dly1_in,
           cfg_dly2_in, cfg_dly3_in, cfg_dly4_in, conv_finished_in,
    output start_conv_out, ena_out, enable_dlycontrol_out, dlycontrol1_out,
           dlycontrol2_out, dlycontrol3_out, dlycontrol4_out, busy_out,
           done_out, timeout_err_out, conv_count_out
  );

  modport master (
    output cfg_enable_in, cfg_continuous_in, conv_request_in, cfg_start_len_in,
           cfg_holdoff_in, cfg_timeout_in, cfg_enable_dly_in, cfg_dly1_in,
           cfg_dly2_in, cfg_dly3_in, cfg_dly4_in, conv_finished_in,
    input  start_conv_out, ena_out, enable_dlycontrol_out, dlycontrol1_out,
           dlycontrol2_out, dlycontrol3_out, dlycontrol4_out, busy_out,
           done_out, timeout_err_out, conv_count_out
  );
endinterface

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: issues start pulses to the SAR clock generator,
// waits for the (asynchronous) finish level with a timeout, enforces a
// holdoff gap, counts completed conversions and shadows delay settings so
// they never change mid-conversion.
module adc_conv_sequencer #(
  parameter int TIMEOUT_W = 12,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_conv_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLDOFF} state_t;

  typedef struct packed {
    logic       en;
    logic [4:0] d1;
    logic [4:0] d2;
    logic [4:0] d3;
    logic [5:0] d4;
  } dly_t;

  // Delay shadows come out of reset at maximum delay, generator disabled.
  localparam dly_t DLY_RST = {1'b0, 5'h1f, 5'h1f, 5'h1f, 6'h3f};

  state_t               state_q, state_d;
  logic [3:0]           start_cnt_q, start_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [7:0]           hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ena_q, ena_d;
  dly_t                 dly_q, dly_d;
  // [0],[1]: two-flop synchronizer; [2]: previous synced value for edge detect
  logic [2:0]           fin_q, fin_d;
  logic                 fin_edge;

  assign fin_edge = fin_q[1] & ~fin_q[2];

  // State and datapath registers; reset aborts any conversion outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_cnt_q <= '0;
      tmo_q       <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ena_q       <= 1'b0;
      dly_q       <= DLY_RST;
      fin_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ena_q       <= ena_d;
      dly_q       <= dly_d;
      fin_q       <= fin_d;
    end
  end

  // Next-state logic: sequencing, timeout, holdoff, counters and shadows.
  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    tmo_d       = tmo_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ena_d       = bus.cfg_enable_in;
    dly_d       = dly_q;
    fin_d       = {fin_q[1:0], bus.conv_finished_in};

    // Shadows track cfg only while no conversion is in flight.
    if (state_q == IDLE || state_q == HOLDOFF)
      dly_d = '{en: bus.cfg_enable_dly_in, d1: bus.cfg_dly1_in, d2: bus.cfg_dly2_in,
                d3: bus.cfg_dly3_in, d4: bus.cfg_dly4_in};

    case (state_q)
      IDLE: begin
        if (!bus.cfg_enable_in) err_d = 1'b0;
        if (bus.cfg_enable_in && (bus.conv_request_in || bus.cfg_continuous_in)) begin
          state_d     = START;
          start_cnt_d = (bus.cfg_start_len_in == 4'd0) ? 4'd1 : bus.cfg_start_len_in;
        end
      end
      START: begin
        if (start_cnt_q <= 4'd1) begin
          state_d = WAIT;
          tmo_d   = '0;
        end else begin
          start_cnt_d = start_cnt_q - 4'd1;
        end
      end
      WAIT: begin
        // tmo_q is 0 in the first WAIT cycle; timeout fires in the cycle the
        // incremented count reaches cfg_timeout_in. Finish wins a tie.
        tmo_d = tmo_q + TIMEOUT_W'(1);
        if (fin_edge) begin
          state_d = HOLDOFF;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          hold_d  = bus.cfg_holdoff_in;
        end else if (tmo_d >= bus.cfg_timeout_in) begin
          state_d = HOLDOFF;
          err_d   = 1'b1;
          hold_d  = bus.cfg_holdoff_in;
        end
      end
      HOLDOFF: begin
        if (hold_q <= 8'd1) state_d = IDLE;
        else                hold_d  = hold_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_conv_out        = (state_q == START);
  assign bus.busy_out              = (state_q == START) || (state_q == WAIT);
  // Loop enable cannot drop while a conversion is running.
  assign bus.ena_out               = ena_q | bus.busy_out;
  assign bus.done_out              = done_q;
  assign bus.timeout_err_out       = err_q;
  assign bus.conv_count_out        = cnt_q;
  assign bus.enable_dlycontrol_out = dly_q.en;
  assign bus.dlycontrol1_out       = dly_q.d1;
  assign bus.dlycontrol2_out       = dly_q.d2;
  assign bus.dlycontrol3_out       = dly_q.d3;
  assign bus.dlycontrol4_out       = dly_q.d4;
endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer. The conversion counter is built
// 4 bits wide so the wrap-around is reachable in a short run.
module tb_adc_conv_sequencer;
  localparam int TW = 12;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  adc_conv_sequencer_if #(.TIMEOUT_W(TW), .CNT_W(CW)) bus();

  adc_conv_sequencer #(.TIMEOUT_W(TW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    bus.conv_request_in = 1'b1;
    tick();
    bus.conv_request_in = 1'b0;
  endtask

  // Wait (bounded) for the start pulse, then return how many cycles it stayed high.
  task automatic meas_start(output int n);
    int t;
    t = 0;
    n = 0;
    while (!bus.start_conv_out && t < 50) begin tick(); t++; end
    while (bus.start_conv_out && n < 50) begin tick(); n++; end
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!bus.done_out && t < 300) begin tick(); t++; end
    chk(tag, bus.done_out, 1);
  endtask

  initial begin
    int n, s, w, gap, exp_cnt;
    bus.cfg_enable_in     = 1'b0;
    bus.cfg_continuous_in = 1'b0;
    bus.conv_request_in   = 1'b0;
    bus.cfg_start_len_in  = 4'd3;
    bus.cfg_holdoff_in    = 8'd2;
    bus.cfg_timeout_in    = 12'd200;
    bus.cfg_enable_dly_in = 1'b1;
    bus.cfg_dly1_in       = 5'd5;
    bus.cfg_dly2_in       = 5'd6;
    bus.cfg_dly3_in       = 5'd7;
    bus.cfg_dly4_in       = 6'd8;
    bus.conv_finished_in  = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_start", bus.start_conv_out, 0);
    chk("rst_busy",  bus.busy_out, 0);
    chk("rst_ena",   bus.ena_out, 0);
    chk("rst_cnt",   bus.conv_count_out, 0);
    chk("rst_dly1",  bus.dlycontrol1_out, 5'h1f);
    chk("rst_dly4",  bus.dlycontrol4_out, 6'h3f);
    chk("rst_dlyen", bus.enable_dlycontrol_out, 0);
    rst_n = 1'b1;
    tick();
    bus.cfg_enable_in = 1'b1;
    tick(); tick();
    chk("idle_dly1", bus.dlycontrol1_out, 5);
    chk("idle_ena",  bus.ena_out, 1);

    // Single shot, start length 3, finish 20 cycles into WAIT
    pulse_req();
    meas_start(n);
    chk("ss_startlen", n, 3);
    chk("ss_busy", bus.busy_out, 1);
    pulse_req();                         // arrives in WAIT: must be dropped
    repeat (18) tick();
    bus.conv_finished_in = 1'b1;
    wait_done("ss_done");
    chk("ss_cnt",  bus.conv_count_out, 1);
    chk("ss_busy_lo", bus.busy_out, 0);
    tick();
    chk("ss_done_pulse", bus.done_out, 0);
    bus.conv_finished_in = 1'b0;
    s = 0;
    repeat (10) begin tick(); s += int'(bus.start_conv_out); end
    chk("ss_no_requeue", s, 0);
    chk("ss_cnt_hold", bus.conv_count_out, 1);

    // Timeout: 50 WAIT cycles with no finish
    bus.cfg_timeout_in = 12'd50;
    pulse_req();
    meas_start(n);
    w = 0;
    s = 0;
    while (bus.busy_out && w < 200) begin tick(); w++; s += int'(bus.done_out); end
    chk("to_wait_len", w, 50);
    chk("to_err",  bus.timeout_err_out, 1);
    chk("to_nodone", s, 0);
    chk("to_cnt",  bus.conv_count_out, 1);
    repeat (5) tick();
    chk("to_sticky", bus.timeout_err_out, 1);
    bus.cfg_enable_in = 1'b0;
    tick();
    chk("to_clear", bus.timeout_err_out, 0);
    chk("dis_ena",  bus.ena_out, 0);

    // Finish edge while idle is ignored
    bus.conv_finished_in = 1'b1;
    s = 0;
    repeat (6) begin tick(); s += int'(bus.done_out); end
    bus.conv_finished_in = 1'b0;
    repeat (4) begin tick(); s += int'(bus.done_out); end
    chk("idle_fin_ign", s, 0);
    chk("idle_fin_cnt", bus.conv_count_out, 1);

    // Shadow freeze: dly1 changes 5 -> 9 during WAIT
    bus.cfg_enable_in = 1'b1;
    tick(); tick();
    pulse_req();
    meas_start(n);
    bus.cfg_dly1_in = 5'd9;
    repeat (5) tick();
    chk("sh_frozen", bus.dlycontrol1_out, 5);
    bus.conv_finished_in = 1'b1;
    wait_done("sh_done");
    chk("sh_hold1", bus.dlycontrol1_out, 5);
    tick();
    chk("sh_load", bus.dlycontrol1_out, 9);
    bus.conv_finished_in = 1'b0;
    chk("sh_cnt", bus.conv_count_out, 2);

    // Disable during WAIT: ena held until finish, then dropped; no new start
    repeat (5) tick();
    pulse_req();
    meas_start(n);
    bus.cfg_enable_in = 1'b0;
    repeat (5) tick();
    chk("dw_ena_held", bus.ena_out, 1);
    chk("dw_busy", bus.busy_out, 1);
    bus.conv_finished_in = 1'b1;
    wait_done("dw_done");
    chk("dw_ena_drop", bus.ena_out, 0);
    chk("dw_cnt", bus.conv_count_out, 3);
    bus.conv_finished_in = 1'b0;
    bus.conv_request_in = 1'b1;
    s = 0;
    repeat (10) begin tick(); s += int'(bus.start_conv_out); end
    bus.conv_request_in = 1'b0;
    chk("dw_no_start", s, 0);

    // Continuous mode, holdoff 4, finish 10 cycles after each start; the
    // 4-bit count runs 4..15 then wraps to 0,1.
    bus.cfg_start_len_in  = 4'd1;
    bus.cfg_holdoff_in    = 8'd4;
    bus.cfg_enable_in     = 1'b1;
    bus.cfg_continuous_in = 1'b1;
    exp_cnt = 3;
    for (int i = 0; i < 14; i++) begin
      w = 0;
      while (!bus.start_conv_out && w < 50) begin tick(); w++; end
      chk("c_start", bus.start_conv_out, 1);
      repeat (10) tick();
      bus.conv_finished_in = 1'b1;
      wait_done("c_done");
      exp_cnt = (exp_cnt + 1) % 16;
      chk("c_cnt", bus.conv_count_out, exp_cnt);
      bus.conv_finished_in = 1'b0;
      if (i == 13) begin
        bus.cfg_continuous_in = 1'b0;
      end else begin
        // Done appears in the first HOLDOFF cycle; 4 HOLDOFF cycles plus the
        // single IDLE cycle put the next start 5 cycles later.
        gap = 0;
        while (!bus.start_conv_out && gap < 50) begin tick(); gap++; end
        chk("c_gap", gap, 5);
      end
    end
    chk("c_wrapped", bus.conv_count_out, 1);
    s = 0;
    repeat (12) begin tick(); s += int'(bus.start_conv_out); end
    chk("c_stop", s, 0);

    // Asynchronous reset in START aborts at once
    bus.cfg_start_len_in = 4'd8;
    pulse_req();
    chk("ar_in_start", bus.start_conv_out, 1);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_start", bus.start_conv_out, 0);
    chk("ar_busy",  bus.busy_out, 0);
    chk("ar_ena",   bus.ena_out, 0);
    chk("ar_done",  bus.done_out, 0);
    chk("ar_err",   bus.timeout_err_out, 0);
    chk("ar_cnt",   bus.conv_count_out, 0);
    chk("ar_dly1",  bus.dlycontrol1_out, 5'h1f);
    chk("ar_dly4",  bus.dlycontrol4_out, 6'h3f);
    chk("ar_dlyen", bus.enable_dlycontrol_out, 0);
    tick();
    rst_n = 1'b1;
    s = 0;
    repeat (20) begin tick(); s += int'(bus.done_out) + int'(bus.start_conv_out); end
    chk("ar_quiet", s, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
